// File: rtl/spi_sram_model.sv
// -----------------------------------------------------------------------------
// spi_sram_model
//   Behavioural SPI SRAM in the style of a 23LC1024. It is intended for
//   simulation benches and small FPGA flows. It supports:
//     - READ (03), FAST_READ (0B), WRITE (02), RDMR (05) and WRMR (01);
//     - byte, page and sequential modes held in the mode register;
//     - gapless streaming, with page or whole-array wrap-around.
//   All logic runs on posedge sclk. ce is active high.
//
// Ports
//   sclk      in   SPI clock. All state changes on its rising edge.
//   reset     in   asynchronous active-high reset.
//   ce        in   chip enable, active high. A low sample aborts the transaction.
//   si        in   serial data in, MSB first.
//   so        out  serial data out, MSB first.
//   so_en     out  high while so carries read or RDMR data.
//   mode      out  current mode register bits MR[7:6].
//   state_dbg out  current FSM state encoding (observability only).
//
// Output protocol: so_en acts as a per-bit valid. so is meaningful only on
// the edges where so_en is high. Each byte is 8 consecutive valid bits,
// MSB first. There is no ready; the host must take every valid bit.
// -----------------------------------------------------------------------------
module spi_sram_model #(
  parameter string      INIT_FILE  = "",
  parameter int         MEM_AW     = 17,
  parameter int         ADDR_BYTES = 3,
  parameter int         PAGE_BYTES = 32,
  parameter int         DUMMY_BITS = 8,
  parameter logic [1:0] MODE_RST   = 2'b01
) (
  input  logic       sclk,
  input  logic       reset,
  input  logic       ce,
  input  logic       si,
  output logic       so,
  output logic       so_en,
  output logic [1:0] mode,
  output logic [2:0] state_dbg
);

  localparam int ADDR_BITS = 8 * ADDR_BYTES;
  localparam int CNT_MAX   = (ADDR_BITS > DUMMY_BITS) ? ADDR_BITS : DUMMY_BITS;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int MEM_DEPTH = 1 << MEM_AW;
  localparam logic [MEM_AW-1:0] PAGE_MASK = MEM_AW'(PAGE_BYTES - 1);

  typedef enum logic [2:0] {
    S_CMD   = 3'd0,
    S_ADDR  = 3'd1,
    S_DUMMY = 3'd2,
    S_RDATA = 3'd3,
    S_WDATA = 3'd4,
    S_WMR   = 3'd5,
    S_RMR   = 3'd6,
    S_END   = 3'd7
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_in;     // shift-in register for command / write / WRMR bytes
  logic [MEM_AW-1:0] r_addr;
  logic [7:0]        r_sh;     // shift-out register for read / RDMR data
  logic              r_fast;
  logic              r_write;
  logic              r_so;
  logic              r_so_en;
  logic [1:0]        r_mode;
  logic [7:0]        r_mem [0:MEM_DEPTH-1];

  logic [7:0]        w_in_byte;
  logic [MEM_AW-1:0] w_addr_in;
  logic [MEM_AW-1:0] w_addr_next;
  logic              w_single;
  logic              w_byte_done;
  logic              w_mem_we;

  // Byte being completed on this edge.
  assign w_in_byte   = {r_in[6:0], si};
  // Address shift. Bits above MEM_AW fall off the top, which gives aliasing.
  assign w_addr_in   = {r_addr[MEM_AW-2:0], si};
  // Page mode wraps the in-page offset and keeps the page number.
  // Every other multi-byte mode wraps the whole array.
  assign w_addr_next = (r_mode == 2'b10)
                     ? ((r_addr & ~PAGE_MASK) | ((r_addr + MEM_AW'(1)) & PAGE_MASK))
                     : (r_addr + MEM_AW'(1));
  // Modes 00 and 11 both allow one data byte only.
  assign w_single    = (r_mode[1] == r_mode[0]);
  assign w_byte_done = (r_cnt == CNT_W'(7));
  assign w_mem_we    = !reset && ce && (r_state == S_WDATA) && w_byte_done;

  // The array has no reset, so its contents survive reset.
  always_ff @(posedge sclk) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= w_in_byte;
    end
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      r_state <= S_CMD;
      r_cnt   <= '0;
      r_in    <= '0;
      r_addr  <= '0;
      r_sh    <= '0;
      r_fast  <= 1'b0;
      r_write <= 1'b0;
      r_so    <= 1'b0;
      r_so_en <= 1'b0;
      r_mode  <= MODE_RST;
    end else if (!ce) begin
      // Abort. Any partly shifted write byte is simply dropped.
      r_state <= S_CMD;
      r_cnt   <= '0;
      r_in    <= '0;
      r_addr  <= '0;
      r_so    <= 1'b0;
      r_so_en <= 1'b0;
    end else begin
      r_so    <= 1'b0;
      r_so_en <= 1'b0;
      case (r_state)
        S_CMD: begin
          r_in  <= w_in_byte;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_byte_done) begin
            r_cnt  <= '0;
            r_addr <= '0;
            case (w_in_byte)
              8'h03: begin r_state <= S_ADDR; r_fast <= 1'b0; r_write <= 1'b0; end
              8'h0B: begin r_state <= S_ADDR; r_fast <= 1'b1; r_write <= 1'b0; end
              8'h02: begin r_state <= S_ADDR; r_fast <= 1'b0; r_write <= 1'b1; end
              8'h05: begin r_state <= S_RMR;  r_sh <= {r_mode, 6'b0}; end
              8'h01: r_state <= S_WMR;
              default: r_state <= S_END;
            endcase
          end
        end
        S_ADDR: begin
          r_addr <= w_addr_in;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(ADDR_BITS - 1)) begin
            r_cnt <= '0;
            if (r_write) begin
              r_state <= S_WDATA;
            end else if (r_fast && (DUMMY_BITS > 0)) begin
              r_state <= S_DUMMY;
            end else begin
              // Fetch now, so the next edge can drive bit 7.
              r_sh    <= r_mem[w_addr_in];
              r_state <= S_RDATA;
            end
          end
        end
        S_DUMMY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DUMMY_BITS - 1)) begin
            r_cnt   <= '0;
            r_sh    <= r_mem[r_addr];
            r_state <= S_RDATA;
          end
        end
        S_RDATA: begin
          r_so    <= r_sh[7];
          r_so_en <= 1'b1;
          r_sh    <= {r_sh[6:0], 1'b0};
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_byte_done) begin
            r_cnt <= '0;
            if (w_single) begin
              r_state <= S_END;
            end else begin
              // Prefetch while bit 0 goes out, so the stream has no gap.
              r_addr <= w_addr_next;
              r_sh   <= r_mem[w_addr_next];
            end
          end
        end
        S_RMR: begin
          r_so    <= r_sh[7];
          r_so_en <= 1'b1;
          r_sh    <= {r_sh[6:0], 1'b0};
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_byte_done) begin
            r_cnt   <= '0;
            r_state <= S_END;
          end
        end
        S_WDATA: begin
          r_in  <= w_in_byte;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_byte_done) begin
            r_cnt <= '0;
            if (w_single) begin
              r_state <= S_END;
            end else begin
              r_addr <= w_addr_next;
            end
          end
        end
        S_WMR: begin
          r_in  <= w_in_byte;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_byte_done) begin
            r_cnt   <= '0;
            r_mode  <= w_in_byte[7:6];
            r_state <= S_END;
          end
        end
        default: begin
          // S_END: ignore si until ce drops.
          r_state <= S_END;
        end
      endcase
    end
  end

  assign so        = r_so;
  assign so_en     = r_so_en;
  assign mode      = r_mode;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_spi_sram_model.sv
// -----------------------------------------------------------------------------
// tb_spi_sram_model
//   Randomised bench for spi_sram_model. A reference byte array and mode value
//   give the expected read bytes. They go into exp_q as each command is
//   issued. A separate monitor collects so bits while so_en is high and
//   compares each complete byte against the head of exp_q.
// -----------------------------------------------------------------------------
module tb_spi_sram_model;

  localparam int AW    = 17;
  localparam int DEPTH = 1 << AW;
  localparam int PAGE  = 32;

  // ---------------- clock / reset / DUT ----------------
  logic       sclk = 1'b0;
  logic       reset;
  logic       ce;
  logic       si;
  logic       so;
  logic       so_en;
  logic [1:0] mode;
  logic [2:0] state_dbg;

  always #5 sclk = ~sclk;

  spi_sram_model dut (
    .sclk      (sclk),
    .reset     (reset),
    .ce        (ce),
    .si        (si),
    .so        (so),
    .so_en     (so_en),
    .mode      (mode),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ref_mem [0:DEPTH-1];
  logic [1:0] ref_mode;
  logic [7:0] wbuf[$];
  int         mon_n    = 0;
  logic [7:0] mon_byte = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge sclk) begin
    if (reset) begin
      mon_n = 0;
    end else if (so_en) begin
      mon_byte = {mon_byte[6:0], so};
      mon_n++;
      if (mon_n == 8) begin
        mon_n = 0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", mon_byte);
        end else begin
          check("read_byte", {24'h0, mon_byte}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int next_addr(input int a, input logic [1:0] m);
    if (m == 2'b10) return a - (a % PAGE) + ((a % PAGE) + 1) % PAGE;
    return (a + 1) % DEPTH;
  endfunction

  function automatic bit single_byte(input logic [1:0] m);
    return (m == 2'b00) || (m == 2'b11);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic bit_out(input logic b);
    @(negedge sclk);
    ce = 1'b1;
    si = b;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bit_out(v[i]);
  endtask

  task automatic finish_txn();
    @(negedge sclk);
    ce = 1'b0;
    si = 1'b0;
    @(negedge sclk);
    check("queue_drained", exp_q.size(), 0);
    check("no_partial_byte", mon_n, 0);
  endtask

  // Upper address bits are random; only the low AW bits may matter.
  function automatic logic [23:0] alias_addr(input int a);
    logic [6:0] hi;
    hi = 7'($urandom_range(0, 127));
    return {hi, 17'(a)};
  endfunction

  task automatic do_write(input int addr);
    int a;
    a = addr;
    foreach (wbuf[i]) begin
      if (i > 0 && single_byte(ref_mode)) break;
      ref_mem[a] = wbuf[i];
      a = next_addr(a, ref_mode);
    end
    send(32'h02, 8);
    send({8'h0, alias_addr(addr)}, 24);
    foreach (wbuf[i]) send({24'h0, wbuf[i]}, 8);
    finish_txn();
  endtask

  task automatic do_read(input int addr, input int n, input bit fast);
    int a;
    a = addr;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && single_byte(ref_mode)) break;
      exp_q.push_back(ref_mem[a]);
      a = next_addr(a, ref_mode);
    end
    send(fast ? 32'h0B : 32'h03, 8);
    send({8'h0, alias_addr(addr)}, 24);
    if (fast) send(32'($urandom), 8);
    repeat (8 * n) bit_out(1'($urandom_range(0, 1)));
    finish_txn();
  endtask

  task automatic do_wrmr(input logic [7:0] v);
    send(32'h01, 8);
    send({24'h0, v}, 8);
    finish_txn();
    ref_mode = v[7:6];
  endtask

  task automatic do_rdmr();
    exp_q.push_back({ref_mode, 6'b0});
    send(32'h05, 8);
    repeat (16) bit_out(1'($urandom_range(0, 1)));
    finish_txn();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int a;
    int n;
    int op;
    ce    = 1'b0;
    si    = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    repeat (3) @(negedge sclk);
    check("reset_so", {31'h0, so}, 0);
    check("reset_so_en", {31'h0, so_en}, 0);
    check("reset_mode", {30'h0, mode}, 32'h1);
    reset    = 1'b0;
    ref_mode = 2'b01;
    @(negedge sclk);

    // Known contents for 0x00..0x7F.
    wbuf.delete();
    for (int i = 0; i < 128; i++) wbuf.push_back(8'($urandom));
    do_write(0);

    // Sequential write then gapless 32-bit read.
    wbuf = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_write(32'h10);
    do_read(32'h10, 4, 1'b0);

    // Array wrap on write and on read.
    wbuf = '{8'h11, 8'h22};
    do_write(DEPTH - 1);
    do_read(DEPTH - 1, 2, 1'b0);

    // Page mode wrap inside a 32-byte page.
    do_wrmr(8'h80);
    wbuf = '{8'hA5, 8'h5A};
    do_write(32'h1F);
    do_read(32'h00, 1, 1'b0);
    do_read(32'h1F, 2, 1'b0);
    do_read(32'h20, 1, 1'b0);

    // Byte mode: one byte only, then RDMR.
    do_wrmr(8'h00);
    wbuf = '{8'h12, 8'h34};
    do_write(32'h40);
    do_read(32'h40, 2, 1'b0);
    do_read(32'h41, 1, 1'b0);
    do_rdmr();

    // FAST_READ latency, then async reset in the middle of the stream.
    do_wrmr(8'h80);
    exp_q.push_back(ref_mem[32'h10]);
    send(32'h0B, 8);
    send(32'h10, 24);
    send(32'h00, 8);
    @(negedge sclk);
    check("fast_no_data_at_40", {31'h0, so_en}, 0);
    @(negedge sclk);
    check("fast_data_at_41", {31'h0, so_en}, 1);
    repeat (11) @(negedge sclk);
    @(posedge sclk);
    #2 reset = 1'b1;
    #1;
    check("midread_reset_so", {31'h0, so}, 0);
    check("midread_reset_so_en", {31'h0, so_en}, 0);
    check("midread_reset_mode", {30'h0, mode}, 32'h1);
    ref_mode = 2'b01;
    @(negedge sclk);
    ce = 1'b0;
    si = 1'b0;
    @(negedge sclk);
    reset = 1'b0;
    @(negedge sclk);
    check("reset_queue_drained", exp_q.size(), 0);

    // ce dropped 5 bits into the second write byte.
    send(32'h02, 8);
    send(32'h50, 24);
    send(32'h77, 8);
    send(32'h13, 5);
    finish_txn();
    ref_mem[32'h50] = 8'h77;
    do_read(32'h50, 2, 1'b0);

    // Randomised mix over the known region.
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 5);
      a  = $urandom_range(0, 32'h77);
      n  = $urandom_range(1, 6);
      case (op)
        0, 1: begin
          wbuf.delete();
          for (int i = 0; i < n; i++) wbuf.push_back(8'($urandom));
          do_write(a);
        end
        2, 3: do_read(a, n, 1'($urandom_range(0, 1)));
        4:    do_wrmr(8'($urandom));
        default: do_rdmr();
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
